// File: rtl/adder_arbiter_pkg.sv
// adder_arbiter_pkg: shared state encoding and default operand width.
// Revision 1.0
`default_nettype none

package adder_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    DONE = 2'b10
  } state_e;

  localparam int DEFAULT_WIDTH = 4;

endpackage

`default_nettype wire

// File: rtl/adder_arbiter_ripple.sv
// full_adder / ripple_adder_n: purely combinational WIDTH-stage ripple-carry chain.
// Revision 1.0
`default_nettype none

module full_adder (
  input  logic a,
  input  logic b,
  input  logic c_in,
  output logic sum,
  output logic c_out
);

  logic w_p;

  assign w_p   = a ^ b;
  assign sum   = w_p ^ c_in;
  assign c_out = (a & b) | (c_in & w_p);

endmodule

module ripple_adder_n
  import adder_arbiter_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic [WIDTH-1:0] sum,
  output logic             c_out
);

  logic [WIDTH:0] w_carry;

  assign w_carry[0] = c_in;

  generate
    for (genvar i = 0; i < WIDTH; i++) begin : g_stage
      full_adder u_fa (
        .a     (a[i]),
        .b     (b[i]),
        .c_in  (w_carry[i]),
        .sum   (sum[i]),
        .c_out (w_carry[i+1])
      );
    end
  endgenerate

  assign c_out = w_carry[WIDTH];

endmodule

`default_nettype wire

// File: rtl/adder_arbiter.sv
// adder_arbiter: round-robin sharing of one ripple adder between two requesters.
// Revision 1.0
`default_nettype none

module adder_arbiter
  import adder_arbiter_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             req0,
  input  logic             req1,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] b0,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b1,
  input  logic             cin0,
  input  logic             cin1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             done0,
  output logic             done1,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);

  state_e           r_state;
  state_e           w_state_nxt;
  logic             r_prio;
  logic             r_owner;
  logic [WIDTH-1:0] r_op_a;
  logic [WIDTH-1:0] r_op_b;
  logic             r_op_cin;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic [1:0]       r_gnt;
  logic [1:0]       r_done;
  logic             r_busy;

  logic             w_sel;
  logic             w_load_ops;
  logic             w_capture;
  logic             w_prio_nxt;
  logic             w_owner_nxt;
  logic [1:0]       w_gnt_nxt;
  logic [1:0]       w_done_nxt;
  logic [WIDTH-1:0] w_sel_a;
  logic [WIDTH-1:0] w_sel_b;
  logic             w_sel_cin;
  logic [WIDTH-1:0] w_add_sum;
  logic             w_add_cout;

  // Contention goes to the priority pointer; a lone request wins outright.
  assign w_sel     = (req0 & req1) ? r_prio : req1;
  assign w_sel_a   = w_sel ? a1 : a0;
  assign w_sel_b   = w_sel ? b1 : b0;
  assign w_sel_cin = w_sel ? cin1 : cin0;

  ripple_adder_n #(
    .WIDTH (WIDTH)
  ) u_adder (
    .a     (r_op_a),
    .b     (r_op_b),
    .c_in  (r_op_cin),
    .sum   (w_add_sum),
    .c_out (w_add_cout)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_gnt_nxt   = r_gnt;
    w_done_nxt  = 2'b00;
    w_prio_nxt  = r_prio;
    w_owner_nxt = r_owner;
    w_load_ops  = 1'b0;
    w_capture   = 1'b0;
    case (r_state)
      IDLE: begin
        if (req0 | req1) begin
          w_state_nxt = EXEC;
          w_owner_nxt = w_sel;
          w_load_ops  = 1'b1;
          w_gnt_nxt   = w_sel ? 2'b10 : 2'b01;
        end
      end
      EXEC: begin
        w_state_nxt = DONE;
        w_capture   = 1'b1;
        w_done_nxt  = r_owner ? 2'b10 : 2'b01;
      end
      DONE: begin
        w_state_nxt = IDLE;
        w_gnt_nxt   = 2'b00;
        w_prio_nxt  = ~r_owner;
      end
      default: begin
        w_state_nxt = IDLE;
        w_gnt_nxt   = 2'b00;
      end
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state  <= IDLE;
      r_prio   <= 1'b0;
      r_owner  <= 1'b0;
      r_op_a   <= '0;
      r_op_b   <= '0;
      r_op_cin <= 1'b0;
      r_sum    <= '0;
      r_cout   <= 1'b0;
      r_gnt    <= 2'b00;
      r_done   <= 2'b00;
      r_busy   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_prio  <= w_prio_nxt;
      r_owner <= w_owner_nxt;
      r_gnt   <= w_gnt_nxt;
      r_done  <= w_done_nxt;
      r_busy  <= (w_state_nxt != IDLE);
      if (w_load_ops) begin
        r_op_a   <= w_sel_a;
        r_op_b   <= w_sel_b;
        r_op_cin <= w_sel_cin;
      end
      if (w_capture) begin
        r_sum  <= w_add_sum;
        r_cout <= w_add_cout;
      end
    end
  end

  assign gnt0  = r_gnt[0];
  assign gnt1  = r_gnt[1];
  assign done0 = r_done[0];
  assign done1 = r_done[1];
  assign sum   = r_sum;
  assign cout  = r_cout;
  assign busy  = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_adder_arbiter.sv
// tb_adder_arbiter: vector table plus scoreboard-checked sequences for adder_arbiter.
// Revision 1.0
`default_nettype none

module tb_adder_arbiter;

  localparam int W = 4;

  logic         clock = 1'b0;
  logic         resetn = 1'b0;
  logic         req0 = 1'b0, req1 = 1'b0, cin0 = 1'b0, cin1 = 1'b0;
  logic [W-1:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
  logic         gnt0, gnt1, done0, done1, cout, busy;
  logic [W-1:0] sum;

  adder_arbiter #(.WIDTH(W)) dut (
    .clock  (clock),
    .resetn (resetn),
    .req0   (req0),
    .req1   (req1),
    .a0     (a0),
    .b0     (b0),
    .a1     (a1),
    .b1     (b1),
    .cin0   (cin0),
    .cin1   (cin1),
    .gnt0   (gnt0),
    .gnt1   (gnt1),
    .done0  (done0),
    .done1  (done1),
    .sum    (sum),
    .cout   (cout),
    .busy   (busy)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    bit           client;
    logic [W-1:0] sum;
    logic         cout;
  } exp_t;

  typedef struct {
    bit           client;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] sum;
    logic         cout;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[8];
  int   n_chk = 0;
  int   n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard: every done pulse must match the oldest outstanding expectation.
  always @(negedge clock) begin
    if (gnt0 | gnt1) chk("gnt_exclusive", {31'b0, gnt0 & gnt1}, 32'd0);
    if (done0 | done1) begin
      chk("done_exclusive", {31'b0, done0 & done1}, 32'd0);
      if (sb.size() == 0) begin
        chk("done_expected", 32'(sb.size()), 32'd1);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("done_client", {31'b0, done1}, {31'b0, e.client});
        chk("sum", {28'b0, sum}, {28'b0, e.sum});
        chk("cout", {31'b0, cout}, {31'b0, e.cout});
      end
    end
  end

  task automatic drive(input bit c, input logic [W-1:0] a, input logic [W-1:0] b, input logic ci);
    if (c) begin a1 = a; b1 = b; cin1 = ci; req1 = 1'b1; end
    else   begin a0 = a; b0 = b; cin0 = ci; req0 = 1'b1; end
  endtask

  task automatic drop_req(input bit c);
    if (c) req1 = 1'b0;
    else   req0 = 1'b0;
  endtask

  task automatic wait_done(input bit c, output int lat);
    bit ok;
    ok  = 1'b0;
    lat = -1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clock);
      if (c ? done1 : done0) begin
        ok  = 1'b1;
        lat = i;
        break;
      end
    end
    chk("done_timeout", {31'b0, ok}, 32'd1);
  endtask

  task automatic push_exp(input bit c, input logic [W-1:0] a, input logic [W-1:0] b, input logic ci);
    logic [W:0] r;
    r = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci};
    sb.push_back('{c, r[W-1:0], r[W]});
  endtask

  initial begin
    int lat;
    int last;
    logic [W-1:0] fa, fb;

    vecs[0] = '{1'b0, 4'b0011, 4'b0101, 1'b0, 4'b1000, 1'b0};
    vecs[1] = '{1'b1, 4'b1111, 4'b0001, 1'b1, 4'b0001, 1'b1};
    vecs[2] = '{1'b1, 4'b1111, 4'b0000, 1'b1, 4'b0000, 1'b1};
    vecs[3] = '{1'b0, 4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0};
    vecs[4] = '{1'b0, 4'b1111, 4'b1111, 1'b1, 4'b1111, 1'b1};
    vecs[5] = '{1'b1, 4'b1010, 4'b0101, 1'b0, 4'b1111, 1'b0};
    vecs[6] = '{1'b0, 4'b1000, 4'b1000, 1'b0, 4'b0000, 1'b1};
    vecs[7] = '{1'b1, 4'b0111, 4'b0001, 1'b0, 4'b1000, 1'b0};

    // Reset held with both clients requesting.
    drive(1'b0, 4'b0001, 4'b0010, 1'b0);
    drive(1'b1, 4'b0110, 4'b0111, 1'b1);
    repeat (3) @(negedge clock);
    chk("rst_gnt0", {31'b0, gnt0}, 32'd0);
    chk("rst_gnt1", {31'b0, gnt1}, 32'd0);
    chk("rst_done0", {31'b0, done0}, 32'd0);
    chk("rst_done1", {31'b0, done1}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_sum", {28'b0, sum}, 32'd0);
    chk("rst_cout", {31'b0, cout}, 32'd0);
    sb.push_back('{1'b0, 4'b0011, 1'b0});
    sb.push_back('{1'b1, 4'b1110, 1'b0});
    resetn = 1'b1;
    @(negedge clock);
    chk("first_gnt0", {31'b0, gnt0}, 32'd1);
    chk("first_gnt1", {31'b0, gnt1}, 32'd0);
    chk("first_busy", {31'b0, busy}, 32'd1);
    wait_done(1'b0, lat);
    drop_req(1'b0);
    wait_done(1'b1, lat);
    drop_req(1'b1);

    // Single-client vectors.
    for (int k = 0; k < 8; k++) begin
      @(negedge clock);
      drive(vecs[k].client, vecs[k].a, vecs[k].b, vecs[k].cin);
      sb.push_back('{vecs[k].client, vecs[k].sum, vecs[k].cout});
      wait_done(vecs[k].client, lat);
      chk("latency", 32'(lat), 32'd1);
      drop_req(vecs[k].client);
    end

    // Contention: both clients keep re-requesting; grants must alternate 0,1,...
    @(negedge clock);
    for (int k = 0; k < 2; k++) begin
      fa = W'(k * 3 + 1);
      fb = W'(k * 5 + 2);
      drive(k[0], fa, fb, k[0]);
      push_exp(k[0], fa, fb, k[0]);
    end
    last = 0;
    for (int k = 0; k < 6; k++) begin
      wait_done(k[0], lat);
      if (k > 0) chk("done_spacing", 32'(cyc - last), 32'd3);
      last = cyc;
      drop_req(k[0]);
      if (k + 2 < 6) begin
        @(negedge clock);
        fa = W'((k + 2) * 3 + 1);
        fb = W'((k + 2) * 5 + 2);
        drive(k[0], fa, fb, k[0]);
        push_exp(k[0], fa, fb, k[0]);
      end
    end

    // Operand change after the selecting edge must not reach the result.
    @(negedge clock);
    drive(1'b0, 4'b0001, 4'b0001, 1'b0);
    sb.push_back('{1'b0, 4'b0010, 1'b0});
    @(negedge clock);
    chk("iso_gnt0", {31'b0, gnt0}, 32'd1);
    a0 = 4'b1111;
    b0 = 4'b1111;
    wait_done(1'b0, lat);
    drop_req(1'b0);

    // Reset during EXEC discards the operation and clears prio.
    @(negedge clock);
    drive(1'b0, 4'b0111, 4'b0001, 1'b0);
    @(negedge clock);
    chk("exec_busy", {31'b0, busy}, 32'd1);
    resetn = 1'b0;
    req0 = 1'b0;
    repeat (2) @(negedge clock);
    chk("mid_rst_done0", {31'b0, done0}, 32'd0);
    chk("mid_rst_gnt0", {31'b0, gnt0}, 32'd0);
    chk("mid_rst_busy", {31'b0, busy}, 32'd0);
    chk("mid_rst_sum", {28'b0, sum}, 32'd0);
    chk("mid_rst_cout", {31'b0, cout}, 32'd0);
    resetn = 1'b1;
    @(negedge clock);
    drive(1'b0, 4'b0100, 4'b0100, 1'b0);
    drive(1'b1, 4'b0011, 4'b0011, 1'b0);
    sb.push_back('{1'b0, 4'b1000, 1'b0});
    sb.push_back('{1'b1, 4'b0110, 1'b0});
    wait_done(1'b0, lat);
    drop_req(1'b0);
    wait_done(1'b1, lat);
    drop_req(1'b1);

    repeat (4) @(negedge clock);
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
